// File: rtl/selftest_pkg.sv
// Shared types and widths for the self-test sequencer and its response checker.
package selftest_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_t;

    localparam int unsigned VEC_W  = 4;
    localparam int unsigned RESP_W = 12;
    localparam int unsigned CNT_W  = 5;

endpackage

// File: rtl/resp_checker.sv
// Parity check of one logic-block response against the golden per-vector parity table.
module resp_checker
    import selftest_pkg::*;
(
    input  logic [RESP_W-1:0]        resp,
    input  logic [VEC_W-1:0]         vec,
    input  logic [(1<<VEC_W)-1:0]    exp_table,
    output logic                     mismatch
);

    always_comb begin
        mismatch = (^resp) != exp_table[vec];
    end

endmodule

// File: rtl/selftest_ctrl.sv
// BIST sequencer: sweeps all input vectors through the logic block, counts parity
// mismatches, records the first failing vector and reports pass/fail.
module selftest_ctrl
    import selftest_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXP_PARITY    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [VEC_W-1:0]  func_in,
    output logic [VEC_W-1:0]  dut_in,
    input  logic [RESP_W-1:0] dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [VEC_W-1:0]  first_fail,
    output logic              fail_valid
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX     = CNT_W'(1 << VEC_W);

    state_t           state;
    state_t           next_state;
    logic [VEC_W-1:0] vec_q;
    logic [3:0]       settle_q;
    logic             mismatch;
    logic             last_vec;
    logic             settled;
    logic [CNT_W-1:0] err_next;

    resp_checker u_resp_checker (
        .resp      (dut_out),
        .vec       (vec_q),
        .exp_table (EXP_PARITY),
        .mismatch  (mismatch)
    );

    always_comb begin
        last_vec = (vec_q == '1);
        settled  = (settle_q == SETTLE_LAST);
        err_next = err_count;
        if (mismatch && err_count != ERR_MAX) begin
            err_next = err_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // abort outranks start and every sweep transition
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start && !abort) next_state = APPLY;
            APPLY:   if (abort) next_state = IDLE;
                     else if (settled) next_state = SAMPLE;
            SAMPLE:  if (abort) next_state = IDLE;
                     else if (last_vec) next_state = DONE;
                     else next_state = APPLY;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == APPLY) || (state == SAMPLE);
        done   = (state == DONE);
        dut_in = busy ? vec_q : func_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q      <= '0;
            settle_q   <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        vec_q      <= '0;
                        settle_q   <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_valid <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                APPLY: begin
                    if (!abort) settle_q <= settle_q + 4'd1;
                end
                SAMPLE: begin
                    if (!abort) begin
                        err_count <= err_next;
                        if (mismatch && !fail_valid) begin
                            first_fail <= vec_q;
                            fail_valid <= 1'b1;
                        end
                        // pass lands on the edge into DONE so it is valid alongside done
                        if (last_vec) begin
                            pass <= (err_next == '0);
                        end else begin
                            vec_q    <= vec_q + VEC_W'(1);
                            settle_q <= '0;
                        end
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_selftest_ctrl.sv
// Directed bench for selftest_ctrl with a behavioural model of the 4-in/12-out logic block.
module tb_selftest_ctrl;

    // {g0..g6,e,f,g,x,y}; g0 is 1 whenever b=d=0
    function automatic logic [11:0] model(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return {(~(b | d)) | a, a ^ b, b & c, c | d, a & d, ~c, a ^ d,
                b, c ^ d, a & b & c, ~(a | b), d};
    endfunction

    function automatic logic [15:0] gold_table();
        logic [15:0] t;
        t = '0;
        for (int v = 0; v < 16; v++) t[v] = ^model(4'(v));
        return t;
    endfunction

    localparam logic [15:0] GOLD = gold_table();

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  func_in;
    logic [3:0]  dut_in;
    logic [11:0] dut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [3:0]  first_fail;
    logic        fail_valid;

    int fault = 0;
    int total = 0;
    int bad   = 0;

    selftest_ctrl #(
        .SETTLE_CYCLES (2),
        .EXP_PARITY    (GOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .func_in    (func_in),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_valid (fail_valid)
    );

    always #5 clk = ~clk;

    // fault 1: y inverted only on vector 5; fault 2: g0 stuck at 0
    always_comb begin
        dut_out = model(dut_in);
        if (fault == 1 && dut_in == 4'd5) dut_out[0] = ~dut_out[0];
        else if (fault == 2) dut_out[11] = 1'b0;
    end

    typedef struct {
        logic [3:0] func_in;
        logic       start;
        logic       abort;
        logic [3:0] exp_dut_in;
        logic       exp_busy;
    } idle_vec_t;

    idle_vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // start pulse, 48 sweep cycles checked step by step, ends sitting in the done cycle
    task automatic sweep(input int mode, input bit extra);
        fault = mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sweep_clear_err", err_count, 0);
        check("sweep_clear_fv", fail_valid, 0);
        for (int c = 1; c <= 48; c++) begin
            check("sweep_step", {busy, done, dut_in}, {1'b1, 1'b0, 4'((c - 1) / 3)});
            start = extra && (c == 10 || c == 30);
            tick();
        end
        start = 1'b0;
        check("sweep_done_at_49", {busy, done}, 2'b01);
    endtask

    initial begin
        int exp_cnt, exp_first, seen;

        tbl[0] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[1] = '{4'h5, 1'b0, 1'b0, 4'h5, 1'b0};
        tbl[2] = '{4'hA, 1'b0, 1'b1, 4'hA, 1'b0};
        tbl[3] = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b0};
        tbl[4] = '{4'h3, 1'b1, 1'b1, 4'h3, 1'b0};
        tbl[5] = '{4'hC, 1'b0, 1'b1, 4'hC, 1'b0};
        tbl[6] = '{4'h9, 1'b0, 1'b0, 4'h9, 1'b0};
        tbl[7] = '{4'h6, 1'b1, 1'b1, 4'h6, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; func_in = 4'h3;
        #12;
        check("rst_outputs", {busy, done, pass, err_count, first_fail, fail_valid}, 0);
        check("rst_dut_in", dut_in, 4'h3);
        rst = 1'b0;
        tick();

        // idle pass-through, abort alone and start+abort together must stay idle
        for (int i = 0; i < 8; i++) begin
            func_in = tbl[i].func_in;
            start   = tbl[i].start;
            abort   = tbl[i].abort;
            tick();
            check("idle_dut_in", dut_in, tbl[i].exp_dut_in);
            check("idle_busy", {busy, done}, {tbl[i].exp_busy, 1'b0});
        end
        start = 1'b0; abort = 1'b0;

        sweep(0, 1'b0);
        check("golden_pass", pass, 1);
        check("golden_err", err_count, 0);
        check("golden_fv", fail_valid, 0);
        tick();
        check("done_one_cycle", {busy, done}, 2'b00);
        check("golden_pass_held", pass, 1);

        sweep(1, 1'b0);
        check("single_err", err_count, 1);
        check("single_first", first_fail, 5);
        check("single_fv", fail_valid, 1);
        check("single_pass", pass, 0);
        tick();
        check("single_held", {pass, err_count, first_fail, fail_valid}, {1'b0, 5'd1, 4'd5, 1'b1});

        exp_cnt = 0; exp_first = -1;
        for (int v = 0; v < 16; v++) begin
            logic [11:0] r;
            r = model(4'(v));
            if (r[11]) begin
                exp_cnt++;
                if (exp_first < 0) exp_first = v;
            end
        end
        sweep(2, 1'b0);
        check("stuck_err", err_count, exp_cnt);
        check("stuck_first", first_fail, exp_first);
        check("stuck_fv", fail_valid, 1);
        check("stuck_pass", pass, 0);
        tick();

        sweep(0, 1'b1);
        check("extra_start_pass", pass, 1);
        tick();

        // abort during cycle 20 of a sweep that already failed vector 5
        fault = 1; func_in = 4'hA;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {busy, done}, 2'b00);
        check("abort_dut_in", dut_in, 4'hA);
        check("abort_partial", {pass, err_count, first_fail, fail_valid}, {1'b0, 5'd1, 4'd5, 1'b1});
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            if (done || busy) seen++;
            tick();
        end
        check("abort_no_done", seen, 0);
        sweep(0, 1'b0);
        check("restart_pass", pass, 1);
        check("restart_err", err_count, 0);
        tick();

        // async reset between edges in cycle 30
        fault = 1; func_in = 4'h6;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 30; c++) tick();
        check("pre_rst_err", err_count, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", {busy, done, pass, err_count, fail_valid}, 0);
        check("async_rst_dut_in", dut_in, 4'h6);
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
